msg_scheduler: RTL



---
 rtl/msg_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/msg_scheduler.sv
// SHA-256 message-schedule stage.
//
// Loads one 512-bit block as 16 big-endian 32-bit words. It then emits
// W_0..W_(ROUNDS-1), one word per output handshake, together with the round
// index t. A 16-word sliding window holds the state, so the schedule is
// produced on the fly.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_var    message word, first word of the block first
//   in_valid  in_var valid this cycle
//   in_ready  block can accept a message word (IDLE/LOAD)
//   w_out     current schedule word W_t (registered)
//   k_num     current round index t (registered)
//   out_valid w_out/k_num valid (RUN)
//   out_ready consumer accepts W_t this cycle
//   busy      high in LOAD and RUN
//   done      one-cycle pulse in the IDLE cycle after W_(ROUNDS-1) is accepted
module msg_scheduler #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_var,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] w_out,
  output logic [5:0]  k_num,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] win [16];
  logic [3:0]  wcnt;
  logic [5:0]  t_cnt;
  logic        done_q;
  logic [31:0] w_new;
  logic        in_acc;
  logic        out_acc;
  logic        last_acc;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign in_acc   = in_valid & in_ready;
  assign out_acc  = out_valid & out_ready;
  assign last_acc = out_acc && (t_cnt == LAST_T);

  // W_(t+16) from the window; the 32-bit sum drops carries naturally.
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_acc) state_nxt = LOAD;
      LOAD:    if (in_acc && (wcnt == 4'd15)) state_nxt = RUN;
      RUN:     if (last_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: everything here is a decode of registered state.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_out     = '0;
    k_num     = '0;
    case (state)
      LOAD: busy = 1'b1;
      RUN: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        busy      = 1'b1;
        w_out     = win[0];
        k_num     = t_cnt;
      end
      default: ;
    endcase
  end

  assign done = done_q;

  // Window, word/round counters and done pulse.
  // wcnt is 4 bits wide: the 16th word wraps it back to 0, ready for the next block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      wcnt   <= '0;
      t_cnt  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_acc;
      if (in_acc) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= in_var;
        wcnt    <= wcnt + 4'd1;
        t_cnt   <= '0;
      end else if (out_acc) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
        t_cnt   <= last_acc ? 6'd0 : t_cnt + 6'd1;
      end
    end
  end

endmodule
